// File: rtl/defines_package.sv
// Shared screen geometry, wireframe SRAM address width and the fill-span record
// exchanged between the wireframe scanner and the colorfill stage.
`ifndef WIREFRAME_ADDR_SIZE
`define WIREFRAME_ADDR_SIZE 19
`endif

package defines_package;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int ADDR_SIZE     = `WIREFRAME_ADDR_SIZE;
  localparam int SPAN_X_W      = $clog2(SCREEN_WIDTH);
  localparam int SPAN_Y_W      = $clog2(SCREEN_HEIGHT);

  typedef struct packed {
    logic [SPAN_Y_W-1:0] y;
    logic [SPAN_X_W-1:0] x0;
    logic [SPAN_X_W-1:0] x1;
  } Span;

endpackage

// File: rtl/wireframe_scan_span_tracker.sv
// span_tracker: leftmost/rightmost set pixel of the current row. The outputs
// already include the pixel sampled this cycle, so the row can be closed without waiting.
module span_tracker #(
  parameter int X_W = 10
) (
  input  logic           clk,
  input  logic           n_rst,
  input  logic           row_clear,
  input  logic           sample,
  input  logic           pix_bit,
  input  logic [X_W-1:0] x,
  output logic           found,
  output logic [X_W-1:0] x0,
  output logic [X_W-1:0] x1
);

  logic           hit;
  logic           found_q;
  logic [X_W-1:0] x0_q;
  logic [X_W-1:0] x1_q;

  assign hit   = sample & pix_bit;
  assign found = found_q | hit;
  assign x0    = (hit && !found_q) ? x : x0_q;
  assign x1    = hit ? x : x1_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      found_q <= 1'b0;
    end else if (row_clear) begin
      found_q <= 1'b0;
    end else begin
      found_q <= found;
    end
  end

  always_ff @(posedge clk) begin
    if (row_clear) begin
      x0_q <= '0;
      x1_q <= '0;
    end else begin
      x0_q <= x0;
      x1_q <= x1;
    end
  end

endmodule

// File: rtl/wireframe_scan.sv
// wireframe_scan: scans the wireframe SRAM row by row and emits one {y,x0,x1} span per non-empty row.
// Build option WF_CLEAR_ON_READ_EN: zero each location one cycle after it is read.
module wireframe_scan
  import defines_package::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int X_W    = $clog2(WIDTH),
  parameter int Y_W    = $clog2(HEIGHT)
) (
  input  logic                            clk,
  input  logic                            n_rst,
  input  logic                            start,
  output logic                            rd_en,
  output logic [`WIREFRAME_ADDR_SIZE-1:0] rd_addr,
  input  logic                            rd_data,
  output logic                            write_en,
  output logic                            wf_data,
  output logic [`WIREFRAME_ADDR_SIZE-1:0] wr_addr,
  output logic                            span_valid,
  input  logic                            span_ready,
  output Span                             span,
  output logic                            done
);

  localparam int AW = `WIREFRAME_ADDR_SIZE;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SCAN  = 3'd1;
  localparam logic [2:0] ST_FLUSH = 3'd2;
  localparam logic [2:0] ST_EMIT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]     state;
  logic [2:0]     state_n;
  logic [X_W-1:0] x;
  logic [X_W-1:0] x_p1;
  logic [Y_W-1:0] y;
  logic [AW-1:0]  addr;
  logic           vld_p1;
  logic           last_col;
  logic           last_row;
  logic           row_end;
  logic           row_adv;
  logic           row_clear;
  logic           trk_found;
  logic [X_W-1:0] trk_x0;
  logic [X_W-1:0] trk_x1;
  Span            span_q;
  logic           span_valid_q;
  logic           done_q;

  assign last_col  = (x == X_W'(WIDTH - 1));
  assign last_row  = (y == Y_W'(HEIGHT - 1));
  assign row_end   = ((state == ST_FLUSH) && !trk_found) || ((state == ST_EMIT) && span_ready);
  assign row_clear = ((state == ST_IDLE) && start) || row_adv;

  always_comb begin
    state_n = state;
    row_adv = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_n = ST_SCAN;
      ST_SCAN:  if (last_col) state_n = ST_FLUSH;
      ST_FLUSH: if (trk_found) state_n = ST_EMIT;
      ST_EMIT:  state_n = ST_EMIT;
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
    if (row_end) begin
      if (last_row) begin
        state_n = ST_DONE;
      end else begin
        state_n = ST_SCAN;
        row_adv = 1'b1;
      end
    end
  end

  // Stage p0: FSM, counters and registered outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= ST_IDLE;
      x            <= '0;
      y            <= '0;
      addr         <= '0;
      vld_p1       <= 1'b0;
      span_q       <= '0;
      span_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state        <= state_n;
      vld_p1       <= rd_en;
      span_valid_q <= (state_n == ST_EMIT);
      done_q       <= (state == ST_DONE);
      if ((state == ST_IDLE) && start) begin
        x    <= '0;
        y    <= '0;
        addr <= '0;
      end
      if (state == ST_SCAN) begin
        addr <= addr + 1'b1;
        x    <= last_col ? '0 : x + 1'b1;
      end
      if (row_adv) y <= y + 1'b1;
      if ((state == ST_FLUSH) && trk_found) begin
        span_q <= '{y: SPAN_Y_W'(y), x0: SPAN_X_W'(trk_x0), x1: SPAN_X_W'(trk_x1)};
      end
    end
  end

  // Stage p1: x of the pixel whose read data is arriving this cycle
  always_ff @(posedge clk) begin
    x_p1 <= x;
  end

  span_tracker #(
    .X_W(X_W)
  ) u_span_tracker (
    .clk      (clk),
    .n_rst    (n_rst),
    .row_clear(row_clear),
    .sample   (vld_p1),
    .pix_bit  (rd_data),
    .x        (x_p1),
    .found    (trk_found),
    .x0       (trk_x0),
    .x1       (trk_x1)
  );

  assign rd_en      = (state == ST_SCAN);
  assign rd_addr    = addr;
  assign span       = span_q;
  assign span_valid = span_valid_q;
  assign done       = done_q;
  assign wf_data    = 1'b0;

`ifdef WF_CLEAR_ON_READ_EN
  logic [AW-1:0] addr_p1;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      addr_p1 <= '0;
    end else begin
      addr_p1 <= addr;
    end
  end

  assign write_en = vld_p1;
  assign wr_addr  = addr_p1;
`else
  assign write_en = 1'b0;
  assign wr_addr  = '0;
`endif

endmodule

// File: tb/tb_wireframe_scan.sv
// Bench for wireframe_scan on an 8x4 screen with a 1-cycle SRAM model; expected spans
// come from a per-row min/max search over the bench's own copy of the image.
module tb_wireframe_scan;
  import defines_package::*;

  localparam int W = 8;
  localparam int H = 4;
  localparam int AW = `WIREFRAME_ADDR_SIZE;
  localparam int EMPTY_CYCLES = H * (W + 1) + 1;

  typedef struct packed { int y; int x0; int x1; } sp_t;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic start = 1'b0;
  logic rd_data = 1'b0;
  logic span_ready = 1'b0;
  logic rd_en, write_en, wf_data, span_valid, done;
  logic [AW-1:0] rd_addr, wr_addr;
  Span span;

  int checks = 0;
  int failures = 0;
  sp_t got_q[$];
  sp_t exp_q[$];
  int stab_err, emit_rd_err, wr_err, addr_err, done_w_err;
  logic [W*H-1:0] mem = '0;
  logic [W*H-1:0] img_flat = '0;
  logic [W*H-1:0] ref_img = '0;
  logic load_now = 1'b0;

  always #5 clk = ~clk;

  wireframe_scan #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .write_en(write_en), .wf_data(wf_data), .wr_addr(wr_addr),
    .span_valid(span_valid), .span_ready(span_ready), .span(span), .done(done)
  );

  always @(posedge clk) begin
    if (load_now) mem <= img_flat;
    else if (write_en) mem[int'(wr_addr)] <= wf_data;
    if (rd_en) rd_data <= mem[int'(rd_addr)];
  end

  function automatic logic [W*H-1:0] px(input int xx, input int yy);
    logic [W*H-1:0] m;
    m = '0;
    m[yy*W+xx] = 1'b1;
    return m;
  endfunction

  task automatic load_img(input logic [W*H-1:0] img);
    ref_img = img;
    img_flat = img;
    @(negedge clk); load_now = 1'b1;
    @(negedge clk); load_now = 1'b0;
  endtask

  task automatic build_exp(input logic [W*H-1:0] img);
    int lo, hi;
    exp_q.delete();
    for (int yy = 0; yy < H; yy++) begin
      lo = -1; hi = -1;
      for (int xx = 0; xx < W; xx++) if (img[yy*W+xx]) begin
        if (lo < 0) lo = xx;
        hi = xx;
      end
      if (lo >= 0) exp_q.push_back('{y: yy, x0: lo, x1: hi});
    end
  endtask

  // Pulses start, then watches one scan: collects accepted spans, drives span_ready, tallies protocol errors.
  task automatic do_scan(input int stall_first, input bit rand_bp, input bit mid_start,
                         output int done_at, output int stalls, output bit timed_out);
    int h, exp_addr;
    bit first_span, prev_rd_en;
    logic [AW-1:0] prev_rd_addr;
    Span held;
    got_q.delete();
    stab_err = 0; emit_rd_err = 0; wr_err = 0; addr_err = 0; done_w_err = 0;
    done_at = -1; stalls = 0; timed_out = 1'b1; h = 0; first_span = 1'b1;
    prev_rd_en = 1'b0; prev_rd_addr = '0; exp_addr = 0; held = '0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (k > 0) @(negedge clk);
      if (wf_data !== 1'b0) wr_err++;
`ifdef WF_CLEAR_ON_READ_EN
      if (write_en !== prev_rd_en || (write_en && wr_addr !== prev_rd_addr)) wr_err++;
`else
      if (write_en !== 1'b0 || wr_addr !== '0) wr_err++;
`endif
      if (rd_en) begin
        if (int'(rd_addr) != exp_addr) addr_err++;
        exp_addr++;
      end
      prev_rd_en = rd_en;
      prev_rd_addr = rd_addr;
      if (done) begin
        done_at = k;
        timed_out = 1'b0;
        @(negedge clk);
        if (done !== 1'b0) done_w_err++;
        break;
      end
      if (span_valid) begin
        if (rd_en) emit_rd_err++;
        if (h == 0) held = span;
        else if (span !== held) stab_err++;
        h++;
        span_ready = first_span ? (h > stall_first) : (rand_bp ? 1'($urandom_range(0, 1)) : 1'b1);
        if (span_ready) begin
          got_q.push_back('{y: int'(span.y), x0: int'(span.x0), x1: int'(span.x1)});
          h = 0;
          first_span = 1'b0;
        end else begin
          stalls++;
        end
      end else begin
        span_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (mid_start) start = (k >= 2 && k <= 20) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    if (exp_addr != W * H) addr_err++;
    span_ready = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b want=0", rd_en); end
    checks++; if (rd_addr !== '0) begin failures++; $display("FAIL reset_rd_addr got=%0d want=0", rd_addr); end
    checks++; if (write_en !== 1'b0 || wr_addr !== '0 || wf_data !== 1'b0) begin
      failures++; $display("FAIL reset_write got we=%b wa=%0d wd=%b want 0/0/0", write_en, wr_addr, wf_data); end
    checks++; if (span_valid !== 1'b0 || span !== '0) begin
      failures++; $display("FAIL reset_span got v=%b span=%h want 0/0", span_valid, span); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    @(negedge clk); n_rst = 1'b1;
  endtask

  task automatic test_empty();
    int done_at, stalls; bit to;
    load_img('0);
    do_scan(0, 1'b0, 1'b0, done_at, stalls, to);
    checks++; if (to) begin failures++; $display("FAIL empty_timeout got=no done want=done"); end
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL empty_spans got=%0d want=0", got_q.size()); end
    checks++; if (done_at != 37) begin failures++; $display("FAIL empty_latency got=%0d want=37", done_at); end
    checks++; if (done_w_err + addr_err + wr_err != 0) begin
      failures++; $display("FAIL empty_protocol got done_w=%0d addr=%0d wr=%0d want 0", done_w_err, addr_err, wr_err); end
  endtask

  task automatic test_spans();
    logic [W*H-1:0] pats [2];
    int done_at, stalls; bit to;
    pats[0] = px(2, 1) | px(5, 1);
    pats[1] = px(7, 3);
    for (int p = 0; p < 2; p++) begin
      load_img(pats[p]);
      build_exp(ref_img);
      do_scan(0, 1'b0, 1'b0, done_at, stalls, to);
      checks++; if (to || got_q.size() != exp_q.size()) begin
        failures++; $display("FAIL spans%0d_count got=%0d want=%0d timeout=%b", p, got_q.size(), exp_q.size(), to); end
      foreach (exp_q[i]) if (i < got_q.size()) begin
        checks++; if (got_q[i] != exp_q[i]) begin failures++;
          $display("FAIL spans%0d_val[%0d] got={%0d,%0d,%0d} want={%0d,%0d,%0d}", p, i,
                   got_q[i].y, got_q[i].x0, got_q[i].x1, exp_q[i].y, exp_q[i].x0, exp_q[i].x1); end
      end
      checks++; if (done_at != EMPTY_CYCLES + exp_q.size() + stalls) begin
        failures++; $display("FAIL spans%0d_latency got=%0d want=%0d", p, done_at, EMPTY_CYCLES + exp_q.size() + stalls); end
      checks++; if (addr_err + wr_err + done_w_err + emit_rd_err != 0) begin failures++;
        $display("FAIL spans%0d_protocol got addr=%0d wr=%0d done_w=%0d emit_rd=%0d want 0", p, addr_err, wr_err, done_w_err, emit_rd_err); end
    end
  endtask

  task automatic test_backpressure();
    int done_at, stalls; bit to;
    load_img(px(0, 0) | px(3, 0) | px(6, 2));
    build_exp(ref_img);
    do_scan(10, 1'b0, 1'b0, done_at, stalls, to);
    checks++; if (to || got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL bp_count got=%0d want=%0d timeout=%b", got_q.size(), exp_q.size(), to); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] != exp_q[i]) begin failures++;
        $display("FAIL bp_val[%0d] got={%0d,%0d,%0d} want={%0d,%0d,%0d}", i,
                 got_q[i].y, got_q[i].x0, got_q[i].x1, exp_q[i].y, exp_q[i].x0, exp_q[i].x1); end
    end
    checks++; if (stalls != 10) begin failures++; $display("FAIL bp_stalls got=%0d want=10", stalls); end
    checks++; if (stab_err != 0 || emit_rd_err != 0) begin
      failures++; $display("FAIL bp_hold got unstable=%0d rd_in_emit=%0d want 0/0", stab_err, emit_rd_err); end
    checks++; if (done_at != 49) begin failures++; $display("FAIL bp_latency got=%0d want=49", done_at); end
    checks++; if (addr_err + wr_err + done_w_err != 0) begin
      failures++; $display("FAIL bp_protocol got addr=%0d wr=%0d done_w=%0d want 0", addr_err, wr_err, done_w_err); end
  endtask

  task automatic test_rescan();
    int done_at, stalls; bit to;
`ifdef WF_CLEAR_ON_READ_EN
    checks++; if (mem !== '0) begin failures++; $display("FAIL rescan_cleared got=%h want=0", mem); end
    ref_img = '0;
`endif
    build_exp(ref_img);
    do_scan(0, 1'b0, 1'b0, done_at, stalls, to);
    checks++; if (to || got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL rescan_count got=%0d want=%0d timeout=%b", got_q.size(), exp_q.size(), to); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] != exp_q[i]) begin failures++;
        $display("FAIL rescan_val[%0d] got={%0d,%0d,%0d} want={%0d,%0d,%0d}", i,
                 got_q[i].y, got_q[i].x0, got_q[i].x1, exp_q[i].y, exp_q[i].x0, exp_q[i].x1); end
    end
    checks++; if (done_at != EMPTY_CYCLES + exp_q.size()) begin
      failures++; $display("FAIL rescan_latency got=%0d want=%0d", done_at, EMPTY_CYCLES + exp_q.size()); end
  endtask

  task automatic test_random_mid_start();
    logic [W*H-1:0] img;
    int done_at, stalls; bit to;
    for (int n = 0; n < 5; n++) begin
      for (int b = 0; b < W * H; b++) img[b] = ($urandom_range(0, 5) == 0);
      load_img(img);
      build_exp(ref_img);
      do_scan(0, 1'b1, 1'b1, done_at, stalls, to);
      checks++; if (to || got_q.size() != exp_q.size()) begin
        failures++; $display("FAIL rand%0d_count got=%0d want=%0d timeout=%b", n, got_q.size(), exp_q.size(), to); end
      foreach (exp_q[i]) if (i < got_q.size()) begin
        checks++; if (got_q[i] != exp_q[i]) begin failures++;
          $display("FAIL rand%0d_val[%0d] got={%0d,%0d,%0d} want={%0d,%0d,%0d}", n, i,
                   got_q[i].y, got_q[i].x0, got_q[i].x1, exp_q[i].y, exp_q[i].x0, exp_q[i].x1); end
      end
      checks++; if (done_at != EMPTY_CYCLES + exp_q.size() + stalls) begin
        failures++; $display("FAIL rand%0d_latency got=%0d want=%0d", n, done_at, EMPTY_CYCLES + exp_q.size() + stalls); end
      checks++; if (addr_err + wr_err + done_w_err + stab_err + emit_rd_err != 0) begin failures++;
        $display("FAIL rand%0d_protocol got addr=%0d wr=%0d done_w=%0d unstable=%0d rd_in_emit=%0d want 0",
                 n, addr_err, wr_err, done_w_err, stab_err, emit_rd_err); end
    end
  endtask

  task automatic test_reset_mid_emit();
    int done_at, stalls; bit to, seen;
    load_img(px(0, 0) | px(3, 0) | px(6, 2));
    seen = 1'b0;
    span_ready = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      seen = span_valid;
    end
    checks++; if (!seen) begin failures++; $display("FAIL rst_emit_reach got=no span_valid want=span_valid"); end
    n_rst = 1'b0;
    #1;
    checks++; if (span_valid !== 1'b0 || span !== '0 || done !== 1'b0) begin
      failures++; $display("FAIL rst_emit_span got v=%b span=%h done=%b want 0", span_valid, span, done); end
    checks++; if (rd_en !== 1'b0 || rd_addr !== '0 || write_en !== 1'b0 || wr_addr !== '0) begin
      failures++; $display("FAIL rst_emit_sram got re=%b ra=%0d we=%b wa=%0d want 0", rd_en, rd_addr, write_en, wr_addr); end
    @(negedge clk); n_rst = 1'b1;
`ifdef WF_CLEAR_ON_READ_EN
    ref_img[W-1:0] = '0;
`endif
    build_exp(ref_img);
    do_scan(0, 1'b0, 1'b0, done_at, stalls, to);
    checks++; if (to || got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL rst_rescan_count got=%0d want=%0d timeout=%b", got_q.size(), exp_q.size(), to); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] != exp_q[i]) begin failures++;
        $display("FAIL rst_rescan_val[%0d] got={%0d,%0d,%0d} want={%0d,%0d,%0d}", i,
                 got_q[i].y, got_q[i].x0, got_q[i].x1, exp_q[i].y, exp_q[i].x0, exp_q[i].x1); end
    end
    checks++; if (addr_err != 0) begin failures++; $display("FAIL rst_rescan_addr got errs=%0d want=0", addr_err); end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_spans();
    test_backpressure();
    test_rescan();
    test_random_mid_start();
    test_reset_mid_emit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wireframe_scan.md
# wireframe_scan

Reader side of the wireframe SRAM. Once the rasterizer has plotted a triangle outline, this block scans the SRAM row by row and finds the leftmost and rightmost set pixel in each row. It emits one fill span per non-empty row over a valid/ready handshake to the colorfill stage. Optionally it clears each location as it reads it, so the SRAM is blank for the next triangle.

## Interface
Parameters:
- WIDTH, default 640: pixels per row.
- HEIGHT, default 480: rows.
- X_W, default $clog2(WIDTH): width of x coordinates.
- Y_W, default $clog2(HEIGHT): width of y coordinates.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  reset, asynchronous, active-low.
- start  in  1  begin a scan; sampled only in IDLE.
- rd_en  out  1  SRAM read strobe.
- rd_addr  out  `WIREFRAME_ADDR_SIZE  read address, y*WIDTH+x.
- rd_data  in  1  SRAM read data, valid the cycle after rd_en.
- write_en  out  1  SRAM clear strobe (WF_CLEAR_ON_READ_EN only).
- wf_data  out  1  clear data, constant 0.
- wr_addr  out  `WIREFRAME_ADDR_SIZE  clear address.
- span_valid  out  1  span output valid.
- span_ready  in  1  consumer accepts span.
- span  out  Span  fields {y, x0, x1}.
- done  out  1  one-cycle pulse at end of scan.

## Operation
States:
- IDLE: waits for start. Goes to SCAN when start=1, with x=0, y=0 and addr=0.
- SCAN: rd_en=1 every cycle, rd_addr = linear counter.
  - Addresses are generated by increment only; no multiplier.
  - Each cycle, x increments. After x=WIDTH-1 is issued, go to FLUSH.
- FLUSH: rd_en=0. Samples the last pixel of the row.
  - If any pixel in the row was set, go to EMIT.
  - Otherwise, if y<HEIGHT-1, increment y and go back to SCAN.
  - Otherwise go to DONE.
- EMIT: span_valid=1 and span is held stable. When span_ready=1, take the same next-row/DONE decision as FLUSH.
- DONE: done=1 for one cycle, then go to IDLE.

Span tracking, applied each cycle rd_data is valid:
- If rd_data=1 and no pixel has been found yet in the row: x0 and x1 are set to that pixel's x.
- If rd_data=1 and a pixel was already found: x1 is set to that pixel's x.
- Per-row found flag and x0/x1 reset at the start of every row.
- A row with a single set pixel emits x0 = x1.
- A row with no set pixel emits nothing.

Boundary cases:
- Pixel x=WIDTH-1 is captured via FLUSH.
- The last row's span is emitted before DONE.
- start outside IDLE is ignored.
- span_ready outside EMIT is ignored.
- Reset at any point, including mid-scan or mid-EMIT, returns to IDLE; any pending span is dropped.

## Timing
- Reset values: every output is 0.
- SRAM read latency is fixed at 1 cycle.
- Scan duration with all rows empty and no backpressure: done asserts exactly HEIGHT*(WIDTH+1)+1 cycles after the cycle in which start is sampled.
- Each emitted span adds at least 1 cycle, plus one cycle per cycle span_ready is held low.
- No reads are issued while in EMIT.
- span is registered and does not change while span_valid=1 and span_ready=0.

## Configuration
- WF_CLEAR_ON_READ_EN defined:
  - In each cycle rd_data is valid, write_en=1 and wr_addr = the address read in the previous cycle.
  - Every location is zeroed by the end of the scan.
  - The SRAM is simple dual-port (one read port, one write port).
- WF_CLEAR_ON_READ_EN undefined: write_en=0 and wr_addr=0 constantly; the SRAM contents are untouched.
- wf_data=0 in both cases.

## Structure
- defines_package contains:
  - typedef Span {y[Y_W], x0[X_W], x1[X_W]};
  - screen width/height constants alongside `WIREFRAME_ADDR_SIZE.
- Sub-module span_tracker holds the found flag and x0/x1.
  - Inputs: clk, n_rst, row_clear, sample, bit, x.
  - Outputs: found, x0, x1.
- wireframe_scan contains the FSM, the address/x/y counters and the output register.

## Test plan
Bench parameters WIDTH=8, HEIGHT=4; 1-cycle SRAM model.
- All-zero SRAM, start: no span_valid; done pulses exactly 37 cycles after start is sampled; done is high for one cycle.
- Set (2,1) and (5,1): exactly one span, {y=1, x0=2, x1=5}.
- Set only (7,3): span {3,7,7} emitted before done, which exercises last-column FLUSH and last-row handling.
- Set (0,0), (3,0), (6,2); hold span_ready=0 for 10 cycles on the first span: span {0,0,3} is stable throughout and rd_en stays 0. Then span {2,6,6} follows, then done.
- With WF_CLEAR_ON_READ_EN, using the previous pattern:
  - write_en accompanies every read with wr_addr = rd_addr-1.
  - A second start yields no spans.
  - Without the macro, the second scan repeats the same spans.
- Assert start mid-scan: ignored. Deassert n_rst mid-EMIT: all outputs are 0 immediately; a new start rescans from (0,0).
